// File: rtl/display_mux_n.sv
// display_mux_n: time-multiplexed driver for a common-anode seven-segment bank.
// Scans N_DIGITS digits, each selected for REFRESH_TICKS cycles. Input values are
// latched once per scan frame, so a frame always shows one coherent value set.
// Supports hex glyphs, decimal points, leading-zero suppression, per-digit blink
// and PWM brightness. All outputs are registered (one cycle behind scan state).
module display_mux_n #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned REFRESH_TICKS = 100000,
  parameter int unsigned DUTY_BITS     = 4,
  parameter int unsigned BLINK_FRAMES  = 250
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*N_DIGITS-1:0]   i_digits,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic [N_DIGITS-1:0]     i_blink_mask,
  input  logic [DUTY_BITS-1:0]    i_brightness,
  input  logic                    i_hex_en,
  input  logic                    i_lz_blank,
  output logic [N_DIGITS-1:0]     o_enabled,
  output logic [6:0]              o_ag,
  output logic                    o_dp_n,
  output logic                    o_frame_tick
);

  localparam int unsigned SlotW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int unsigned IdxW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FrmW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(REFRESH_TICKS - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DIGITS - 1);
  localparam logic [FrmW-1:0]  FrmLast  = FrmW'(BLINK_FRAMES - 1);

  localparam logic [6:0] GlyphBlank = 7'b1111111;

  // Segment pattern in ag[6:0] order (active low); hex letters only when enabled.
  function automatic logic [6:0] f_glyph(input logic [3:0] val, input logic hex_en);
    logic [6:0] g;
    case (val)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (val > 4'h9 && !hex_en) begin
      g = GlyphBlank;
    end
    return g;
  endfunction

  // Scan timing state
  logic [SlotW-1:0]      r_slot_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [FrmW-1:0]       r_frame_cnt;
  logic                  r_blink_phase;
  logic [DUTY_BITS-1:0]  r_pwm_cnt;
  logic                  r_frame_tick;

  // Per-frame shadow copies of the display inputs
  logic [4*N_DIGITS-1:0] r_sh_digits;
  logic [N_DIGITS-1:0]   r_sh_dp;
  logic [N_DIGITS-1:0]   r_sh_blink;
  logic                  r_sh_hex;
  logic                  r_sh_lz;

  // Registered pin drivers
  logic [N_DIGITS-1:0]   r_enabled;
  logic [6:0]            r_ag;
  logic                  r_dp_n;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [3:0]            w_cur_val;
  logic                  w_cur_dp;
  logic                  w_cur_blink;
  logic                  w_cur_sup;
  logic                  w_all_zero;
  logic                  w_anode_on;
  logic [6:0]            w_ag_d;
  logic                  w_dp_n_d;
  logic [N_DIGITS-1:0]   w_enabled_d;

  assign w_slot_end  = (r_slot_cnt == SlotLast);
  assign w_frame_end = w_slot_end && (r_idx == IdxLast);

  // Slot/digit scan, PWM counter, frame strobe, shadow latch and blink phase
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_pwm_cnt     <= '0;
      r_frame_tick  <= 1'b0;
      r_sh_digits   <= '0;
      r_sh_dp       <= '0;
      r_sh_blink    <= '0;
      r_sh_hex      <= 1'b0;
      r_sh_lz       <= 1'b0;
    end else begin
      r_pwm_cnt    <= r_pwm_cnt + DUTY_BITS'(1);
      r_frame_tick <= w_frame_end;
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_idx      <= w_frame_end ? '0 : r_idx + IdxW'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SlotW'(1);
      end
      if (w_frame_end) begin
        r_sh_digits <= i_digits;
        r_sh_dp     <= i_dp;
        r_sh_blink  <= i_blink_mask;
        r_sh_hex    <= i_hex_en;
        r_sh_lz     <= i_lz_blank;
        if (r_frame_cnt == FrmLast) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FrmW'(1);
        end
      end
    end
  end

  // Select the current digit's shadow data; a digit is suppressed when it and
  // every more-significant digit are zero (digit 0 never is)
  always_comb begin
    w_cur_val   = 4'h0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    w_cur_sup   = 1'b0;
    w_all_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_all_zero = w_all_zero && (r_sh_digits[4*i +: 4] == 4'h0);
      if (r_idx == IdxW'(i)) begin
        w_cur_val   = r_sh_digits[4*i +: 4];
        w_cur_dp    = r_sh_dp[i];
        w_cur_blink = r_sh_blink[i];
        w_cur_sup   = r_sh_lz && (i != 0) && w_all_zero;
      end
    end
  end

  // Next pin values: glyph, suppression, blink blanking and PWM-gated anode
  always_comb begin
    w_ag_d   = w_cur_sup ? GlyphBlank : f_glyph(w_cur_val, r_sh_hex);
    w_dp_n_d = ~w_cur_dp;
    if (r_blink_phase && w_cur_blink) begin
      w_ag_d   = GlyphBlank;
      w_dp_n_d = 1'b1;
    end
    w_anode_on  = (r_pwm_cnt <= i_brightness);
    w_enabled_d = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_anode_on && (r_idx == IdxW'(i))) begin
        w_enabled_d[i] = 1'b0;
      end
    end
  end

  // Output registers; reset blanks the display immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_enabled <= '1;
      r_ag      <= GlyphBlank;
      r_dp_n    <= 1'b1;
    end else begin
      r_enabled <= w_enabled_d;
      r_ag      <= w_ag_d;
      r_dp_n    <= w_dp_n_d;
    end
  end

  assign o_enabled    = r_enabled;
  assign o_ag         = r_ag;
  assign o_dp_n       = r_dp_n;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_mux_n.sv
// Randomized bench for display_mux_n: two instances (4-digit and 1-digit) are
// compared every cycle against a model that derives scan position, PWM phase,
// frame number and blink phase arithmetically from the cycle count since reset.
module tb_display_mux_n;

  localparam int N0 = 4, R0 = 4, D0 = 3, B0 = 2;
  localparam int N1 = 1, R1 = 3, D1 = 1, B1 = 1;

  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst;

  logic [4*N0-1:0] dig0;
  logic [N0-1:0]   dp0, bm0, en0;
  logic [D0-1:0]   br0;
  logic            hex0, lz0, dpn0, ft0;
  logic [6:0]      ag0;

  logic [4*N1-1:0] dig1;
  logic [N1-1:0]   dp1, bm1, en1;
  logic [D1-1:0]   br1;
  logic            hex1, lz1, dpn1, ft1;
  logic [6:0]      ag1;

  // Model shadow state and cycle count since reset release
  logic [31:0] m0_dig, m1_dig;
  logic [7:0]  m0_dp, m0_bm, m1_dp, m1_bm;
  logic        m0_hex, m0_lz, m1_hex, m1_lz;
  longint      k;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_mux_n #(
    .N_DIGITS(N0), .REFRESH_TICKS(R0), .DUTY_BITS(D0), .BLINK_FRAMES(B0)
  ) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_digits(dig0), .i_dp(dp0), .i_blink_mask(bm0),
    .i_brightness(br0), .i_hex_en(hex0), .i_lz_blank(lz0),
    .o_enabled(en0), .o_ag(ag0), .o_dp_n(dpn0), .o_frame_tick(ft0)
  );

  display_mux_n #(
    .N_DIGITS(N1), .REFRESH_TICKS(R1), .DUTY_BITS(D1), .BLINK_FRAMES(B1)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_digits(dig1), .i_dp(dp1), .i_blink_mask(bm1),
    .i_brightness(br1), .i_hex_en(hex1), .i_lz_blank(lz1),
    .o_enabled(en1), .o_ag(ag1), .o_dp_n(dpn1), .o_frame_tick(ft1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, k=%0d)", tag, act, exp, $time, k);
    end
  endtask

  // Expected pins after edge k, from the display rules in plain arithmetic
  function automatic void model(input int n, input int r, input int d, input int b,
                                input longint kk, input logic [31:0] sdig,
                                input logic [7:0] sdp, input logic [7:0] sbm,
                                input logic shex, input logic slz, input int bright,
                                output logic [7:0] en, output logic [6:0] ag,
                                output logic dpn, output logic ft);
    int idx, f, pwm;
    logic [3:0] val;
    logic sup, phase;
    idx   = int'((kk / r) % n);
    f     = int'(kk / (n * r));
    pwm   = int'(kk % (1 << d));
    val   = 4'((sdig >> (4 * idx)) & 32'hF);
    sup   = slz && (idx != 0) && ((sdig >> (4 * idx)) == 0);
    phase = ((f / b) % 2) == 1;
    ag    = (val > 9 && !shex) ? 7'h7F : GLYPH_TAB[val];
    if (sup) ag = 7'h7F;
    dpn = !sdp[idx];
    if (phase && sbm[idx]) begin
      ag  = 7'h7F;
      dpn = 1'b1;
    end
    en = 8'hFF;
    if (pwm <= bright) en[idx] = 1'b0;
    ft = ((kk + 1) % (n * r)) == 0;
  endfunction

  task automatic clear_model();
    k = 0;
    m0_dig = '0; m0_dp = '0; m0_bm = '0; m0_hex = 1'b0; m0_lz = 1'b0;
    m1_dig = '0; m1_dp = '0; m1_bm = '0; m1_hex = 1'b0; m1_lz = 1'b0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_en0"}, 32'(en0), 32'hF);
    check({tag, "_ag0"}, 32'(ag0), 32'h7F);
    check({tag, "_dpn0"}, 32'(dpn0), 32'h1);
    check({tag, "_ft0"}, 32'(ft0), 32'h0);
    check({tag, "_en1"}, 32'(en1), 32'h1);
    check({tag, "_ag1"}, 32'(ag1), 32'h7F);
    check({tag, "_dpn1"}, 32'(dpn1), 32'h1);
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < N0; i++)
        dig0[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    end
    if ($urandom_range(0, 7) == 0) dp0 = N0'($urandom);
    if ($urandom_range(0, 7) == 0) bm0 = N0'($urandom);
    if ($urandom_range(0, 7) == 0) hex0 = 1'($urandom);
    if ($urandom_range(0, 7) == 0) lz0 = 1'($urandom);
    if ($urandom_range(0, 5) == 0) br0 = ($urandom_range(0, 2) == 0) ? '1 : D0'($urandom);
    if ($urandom_range(0, 3) == 0) dig1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    if ($urandom_range(0, 7) == 0) dp1 = N1'($urandom);
    if ($urandom_range(0, 7) == 0) bm1 = N1'($urandom);
    if ($urandom_range(0, 7) == 0) hex1 = 1'($urandom);
    if ($urandom_range(0, 7) == 0) lz1 = 1'($urandom);
    if ($urandom_range(0, 5) == 0) br1 = D1'($urandom);
  endtask

  // Check the pins produced by the latest edge, then advance the model
  task automatic step();
    logic [7:0] e_en;
    logic [6:0] e_ag;
    logic       e_dpn, e_ft;
    @(negedge clk);
    model(N0, R0, D0, B0, k, m0_dig, m0_dp, m0_bm, m0_hex, m0_lz, int'(br0),
          e_en, e_ag, e_dpn, e_ft);
    check("en0", 32'(en0), 32'(e_en[N0-1:0]));
    check("ag0", 32'(ag0), 32'(e_ag));
    check("dpn0", 32'(dpn0), 32'(e_dpn));
    check("ft0", 32'(ft0), 32'(e_ft));
    if (((k + 1) % (N0 * R0)) == 0) begin
      m0_dig = 32'(dig0); m0_dp = 8'(dp0); m0_bm = 8'(bm0);
      m0_hex = hex0; m0_lz = lz0;
    end
    model(N1, R1, D1, B1, k, m1_dig, m1_dp, m1_bm, m1_hex, m1_lz, int'(br1),
          e_en, e_ag, e_dpn, e_ft);
    check("en1", 32'(en1), 32'(e_en[N1-1:0]));
    check("ag1", 32'(ag1), 32'(e_ag));
    check("dpn1", 32'(dpn1), 32'(e_dpn));
    check("ft1", 32'(ft1), 32'(e_ft));
    if (((k + 1) % (N1 * R1)) == 0) begin
      m1_dig = 32'(dig1); m1_dp = 8'(dp1); m1_bm = 8'(bm1);
      m1_hex = hex1; m1_lz = lz1;
    end
    k++;
    randomize_inputs();
  endtask

  initial begin
    rst  = 1'b1;
    dig0 = 16'h1234; dp0 = '0; bm0 = '0; br0 = '1; hex0 = 1'b0; lz0 = 1'b0;
    dig1 = 4'h7;     dp1 = '0; bm1 = '0; br1 = '1; hex1 = 1'b0; lz1 = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_blank("rst");
    rst = 1'b0;
    repeat (1500) step();

    // Reset mid-frame, between clock edges: outputs must blank at once
    #2 rst = 1'b1;
    #1 check_blank("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_blank("rst_hold");
    end
    rst = 1'b0;
    clear_model();
    repeat (1500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_mux_n.md
# display_mux_n

Parametrised time-multiplexed driver for common-anode seven-segment banks of 1–8 digits. It is the next generation of the team's 4-digit scanner and adds:
- a configurable per-digit slot length
- hex glyphs, decimal points and leading-zero suppression
- per-digit blink and PWM brightness
- frame-coherent input latching and a frame strobe

It sits between the value formatting logic and the board's anode/segment pins.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_TICKS, 100000, clk cycles each digit is selected (≥2)
- DUTY_BITS, 4, width of brightness control and PWM counter (1..8)
- BLINK_FRAMES, 250, scan frames per blink half-period (≥1)
- clk  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- digits  in  4*N_DIGITS  nibble i = value of digit i (digit 0 rightmost)
- dp  in  N_DIGITS  decimal point request per digit, active high
- blink_mask  in  N_DIGITS  digits that blink, active high
- brightness  in  DUTY_BITS  PWM duty code
- hex_en  in  1  1: values 10–15 show A b C d E F; 0: shown blank
- lz_blank  in  1  1: suppress leading zeros
- enabled  out  N_DIGITS  anode selects, active low
- ag  out  7  segments, active low, ag[0]=a … ag[6]=g
- dp_n  out  1  decimal point segment, active low
- frame_tick  out  1  one-cycle pulse at end of each full scan frame

## Operation
- slot_cnt counts 0..REFRESH_TICKS-1. At terminal count it wraps to 0 and idx advances 0→1→…→N_DIGITS-1→0.
- Frame end is slot_cnt==REFRESH_TICKS-1 with idx==N_DIGITS-1. On that edge:
  - digits, dp, blink_mask, hex_en and lz_blank are copied into shadow registers.
  - frame_tick pulses.
  - Input changes never affect a frame in progress.
- Leading-zero suppression, computed from shadow values:
  - Digit i is blanked when lz_blank=1, i≠0, and shadow digits i..N_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A digit's dp is still shown when that digit is suppressed.
- Glyphs, in ag[6:0] order:
  - 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Values 10–15 with hex_en=0: 1111111
- Blink:
  - frame_cnt counts frame_ticks 0..BLINK_FRAMES-1.
  - At wrap, blink_phase toggles.
  - While blink_phase=1, digits with shadow blink_mask bit set are fully blanked (ag=1111111, dp_n=1, anode still driven).
- PWM:
  - pwm_cnt is a free-running DUTY_BITS counter, wrapping at 2^DUTY_BITS-1→0.
  - The anode is asserted only while pwm_cnt ≤ brightness, so duty = (brightness+1)/2^DUTY_BITS. Maximum code gives 100%; code 0 gives the minimum non-zero duty.
  - brightness is sampled live, not shadowed.
- When the anode is off, enabled is all ones; ag and dp_n keep the slot's glyph.
- Only one bit of enabled is ever low.

## Timing
- All outputs are registered. enabled/ag/dp_n reflect idx, shadow state and pwm_cnt from the previous cycle (latency 1 cycle).
- Reset state, applied asynchronously:
  - enabled all ones, ag=1111111, dp_n=1, frame_tick=0
  - slot_cnt, idx, frame_cnt, pwm_cnt and blink_phase = 0
  - shadow registers = 0
- Reset asserted mid-frame blanks outputs immediately. After deassertion, scanning restarts at digit 0, slot_cnt 0.
- Until the first frame_tick, shadow values are zero, so the display shows 0 (or blank digits 1..N-1 if the zero lz_blank shadow would suppress; it does not, since the shadow is 0).
- frame_tick is high for exactly the one cycle after the frame-end edge. Period = N_DIGITS*REFRESH_TICKS cycles.
- N_DIGITS=1: idx is constant 0; frame_tick still pulses every REFRESH_TICKS cycles.
- Frame wrap and blink wrap on the same edge: shadow load, frame_tick and blink_phase toggle all take effect together.

## Test plan
1. Reset and scan. Assert reset mid-run with N_DIGITS=4, REFRESH_TICKS=4, brightness max, digits=0x1234. Required:
   - During reset: enabled=1111, ag=1111111, dp_n=1.
   - After release: enabled sequence 1110,1101,1011,0111, each held 4 cycles.
   - First frame shows 0; second frame shows 4,3,2,1 glyphs.
   - frame_tick every 16 cycles.
2. Frame coherence. Change digits from 0x1234 to 0x5678 while idx=1. Required: that frame completes with 1234 glyphs; 5678 glyphs appear from the next frame.
3. Leading zeros. digits=0x0070, lz_blank=1, dp=0100. Required:
   - Digit 3 ag=1111111, dp_n=1.
   - Digit 2 ag=1111111, dp_n=0.
   - Digit 1 ag=1111000; digit 0 ag=1000000.
   - With digits=0x0000, only digit 0 is lit, showing 0.
4. Hex mode. digits=0xABCF. With hex_en=1, required glyphs per digit are F,C,b,A. With hex_en=0, all four are ag=1111111.
5. Brightness. DUTY_BITS=4, brightness=3, REFRESH_TICKS=32. Required: the selected anode is low for exactly 8 of 32 cycles in each slot. brightness=15 gives 32 of 32.
6. Blink. BLINK_FRAMES=2, blink_mask=0001. Required: digit 0 is blanked in frames 2–3, shown in frames 4–5, and so on. Other digits are unaffected.
